// File: rtl/modcnt_pkg.sv
// Shared constants for the programmable modulo counter: direction encoding,
// default sizing and the per-cycle control-priority encoding.
package modcnt_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int unsigned MODCNT_DEFAULT_N     = 8;
   localparam int unsigned MODCNT_DEFAULT_MOD   = 159;
   localparam int unsigned MODCNT_DEFAULT_WRAPW = 16;

   localparam logic [1:0] CTL_CLEAR = 2'd0;
   localparam logic [1:0] CTL_LOAD  = 2'd1;
   localparam logic [1:0] CTL_COUNT = 2'd2;
   localparam logic [1:0] CTL_HOLD  = 2'd3;

   // Resolve the control inputs into one action: clear beats load beats enable
   function automatic logic [1:0] ctl_select(input logic clear,
                                             input logic load,
                                             input logic en);
      if (clear)
         return CTL_CLEAR;
      else if (load)
         return CTL_LOAD;
      else if (en)
         return CTL_COUNT;
      else
         return CTL_HOLD;
   endfunction

endpackage

// File: rtl/modcnt_mod_shadow.sv
// Terminal-value holder for the modulo counter. A newly written modulus waits
// in a shadow register until the counter wraps or is cleared, so a running
// period is never cut short or stretched. A write that lands on the same
// edge as the apply strobe goes straight to the active modulus.
module modcnt_mod_shadow #(
   parameter int unsigned    N         = 8,
   parameter logic [N-1:0]   RESET_MOD = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         mod_wr,
   input  logic [N-1:0] mod_in,
   input  logic         apply,
   output logic [N-1:0] mod_cur,
   output logic [N-1:0] mod_next
);

   logic [N-1:0] shadow;
   logic         pending;

   // Modulus that will be active after this edge; also the down-wrap reload
   always_comb begin
      mod_next = mod_cur;
      if (apply) begin
         if (mod_wr)
            mod_next = mod_in;
         else if (pending)
            mod_next = shadow;
      end
   end

   // Commit the next modulus on apply, otherwise park writes in the shadow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mod_cur <= RESET_MOD;
         shadow  <= '0;
         pending <= 1'b0;
      end else if (apply) begin
         mod_cur <= mod_next;
         pending <= 1'b0;
      end else if (mod_wr) begin
         shadow  <= mod_in;
         pending <= 1'b1;
      end
   end

endmodule

// File: rtl/prog_modulo_counter.sv
// Up/down modulo counter with a runtime-programmable terminal value,
// synchronous clear/load and a cascadable wrap carry (wrap -> next stage en).
// Optional feature macro MODCNT_WRAPCNT_EN adds a saturating wrap_count output.
module prog_modulo_counter
   import modcnt_pkg::*;
#(
   parameter int unsigned N           = MODCNT_DEFAULT_N,
   parameter int unsigned DEFAULT_MOD = MODCNT_DEFAULT_MOD,
   parameter int unsigned WRAPW       = MODCNT_DEFAULT_WRAPW
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   input  logic         up,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         mod_wr,
   input  logic [N-1:0] mod_in,
   output logic [N-1:0] count,
   output logic [N-1:0] mod_cur,
   output logic         tc,
   output logic         wrap
`ifdef MODCNT_WRAPCNT_EN
   ,
   output logic [WRAPW-1:0] wrap_count
`endif
);

   localparam logic [N-1:0] RESET_MOD = DEFAULT_MOD[N-1:0];

   logic [1:0]   ctl;
   logic [N-1:0] count_next;
   logic [N-1:0] mod_next;
   logic         apply;

   // Terminal count is judged against the direction in effect this cycle
   assign tc    = (up == DIR_UP) ? (count == mod_cur) : (count == '0);
   assign wrap  = en & tc & ~clear & ~load;
   assign apply = wrap | clear;

   modcnt_mod_shadow #(
      .N         (N),
      .RESET_MOD (RESET_MOD)
   ) u_mod_shadow (
      .clk      (clk),
      .reset    (reset),
      .mod_wr   (mod_wr),
      .mod_in   (mod_in),
      .apply    (apply),
      .mod_cur  (mod_cur),
      .mod_next (mod_next)
   );

   // Next count: clear, clamped load, wrapping step in either direction, or hold
   always_comb begin
      ctl        = ctl_select(clear, load, en);
      count_next = count;
      case (ctl)
         CTL_CLEAR: count_next = '0;
         CTL_LOAD:  count_next = (load_val > mod_cur) ? mod_cur : load_val;
         CTL_COUNT: begin
            if (up == DIR_UP)
               count_next = tc ? '0 : count + 1'b1;
            else
               count_next = tc ? mod_next : count - 1'b1;
         end
         default:   count_next = count;
      endcase
   end

   // Count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else
         count <= count_next;
   end

`ifdef MODCNT_WRAPCNT_EN
   // Saturating tally of wraps, zeroed together with the count on clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wrap_count <= '0;
      else if (clear)
         wrap_count <= '0;
      else if (wrap && (wrap_count != '1))
         wrap_count <= wrap_count + 1'b1;
   end
`else
   // WRAPW only sizes the wrap counter; a zero width would be meaningless
   if (WRAPW == 0) begin : g_wrapw_zero
   end
`endif

endmodule
